time_setter: RTL



---
 rtl/time_setter_pkg.sv | 61 ++++++
 rtl/time_setter_btn_repeat.sv | 67 ++++++
 rtl/time_setter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/time_setter_pkg.sv
// Shared definitions for the time_setter block: field widths, legal limits,
// FSM state encoding, field_sel codes and the per-field step helpers.
// Latency: n/a (package). Backpressure: n/a (package).
package time_setter_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int TIME_W = HOUR_W + MIN_W + SEC_W;  // 17: hhhhh_mmmmmm_ssssss

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MS_MAX   = 6'd59;  // shared by minutes and seconds

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SET_HOUR = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_SET_SEC  = 3'd3,
    ST_COMMIT   = 3'd4
  } state_t;

  localparam logic [1:0] FSEL_NONE = 2'd0;
  localparam logic [1:0] FSEL_HOUR = 2'd1;
  localparam logic [1:0] FSEL_MIN  = 2'd2;
  localparam logic [1:0] FSEL_SEC  = 2'd3;

  // Field layout of the clockwork overwrite bus.
  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } hms_t;

  // One up/down step of the hour field. Wraps 23<->0; an out-of-range captured
  // value snaps to 0 on up and to 23 on down. Both or neither: no change.
  function automatic logic [HOUR_W-1:0] step_hour(input logic [HOUR_W-1:0] v,
                                                  input logic inc,
                                                  input logic dec);
    logic [HOUR_W-1:0] r;
    r = v;
    if (inc && !dec)
      r = (v >= HOUR_MAX) ? '0 : v + HOUR_W'(1);
    else if (dec && !inc)
      r = (v == '0 || v > HOUR_MAX) ? HOUR_MAX : v - HOUR_W'(1);
    return r;
  endfunction

  // Same rules for minutes/seconds with a 59 limit.
  function automatic logic [MIN_W-1:0] step_ms(input logic [MIN_W-1:0] v,
                                               input logic inc,
                                               input logic dec);
    logic [MIN_W-1:0] r;
    r = v;
    if (inc && !dec)
      r = (v >= MS_MAX) ? '0 : v + MIN_W'(1);
    else if (dec && !inc)
      r = (v == '0 || v > MS_MAX) ? MS_MAX : v - MIN_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/time_setter_btn_repeat.sv
// Button press edge detect plus auto-repeat: single-cycle step pulse on press,
// again REPEAT_DLY cycles later, then every REPEAT_PER cycles while held.
// Latency: step is combinational in the press cycle; no backpressure.
//
// Ports:
//   clk, rst_n  clock and async active-low reset
//   level       debounced button level
//   enable      repeat allowed (owner is in an edit state)
//   clear       field is changing this cycle; drop the step and disarm
//   step        one-cycle step request
// REPEAT_DLY and REPEAT_PER must both be >= 1.
module time_setter_btn_repeat #(
  parameter int unsigned REPEAT_DLY = 50000000,
  parameter int unsigned REPEAT_PER = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  input  logic enable,
  input  logic clear,
  output logic step
);

  localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LOAD = CNT_W'(REPEAT_PER - 1);

  logic             prev;
  logic             hist_vld;  // low for the first cycle out of reset
  logic             armed;
  logic [CNT_W-1:0] cnt;       // cycles left until the next repeat step
  logic             press;
  logic             run;
  logic             rpt_tick;

  // hist_vld suppresses the false edge a button held through reset would give.
  assign press    = level & ~prev & hist_vld;
  assign run      = enable & ~clear & level;
  assign rpt_tick = armed & (cnt == '0);
  assign step     = run & (press | rpt_tick);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= 1'b0;
      hist_vld <= 1'b0;
      armed    <= 1'b0;
      cnt      <= '0;
    end else begin
      prev     <= level;
      hist_vld <= 1'b1;
      if (!run) begin
        // Release, field change or leaving edit: only a fresh press re-arms.
        armed <= 1'b0;
        cnt   <= '0;
      end else if (press) begin
        armed <= 1'b1;
        cnt   <= DLY_LOAD;
      end else if (rpt_tick) begin
        cnt <= PER_LOAD;
      end else if (armed) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/time_setter.sv
// Button-driven time entry: captures the running time, edits h/m/s with
// auto-repeating up/down, then writes it to the clockwork with a time_ow strobe.
// Latency: actions register on the edge after a press; no backpressure (strobe only).
//
// Ports:
//   clk, rst_n                       clock and async active-low reset
//   time_cur[16:0]                   running time from the clockwork
//   btn_mode/up/down/cancel          debounced, synchronised button levels
//   time_set[16:0]                   edit value, drives clockwork time_in
//   time_ow                          overwrite strobe, OW_CYCLES long on commit
//   editing, field_sel[1:0]          edit status for the display
module time_setter
  import time_setter_pkg::*;
#(
  parameter int unsigned REPEAT_DLY = 50000000,
  parameter int unsigned REPEAT_PER = 10000000,
  parameter int unsigned OW_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TIME_W-1:0] time_cur,
  input  logic              btn_mode,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_cancel,
  output logic [TIME_W-1:0] time_set,
  output logic              time_ow,
  output logic              editing,
  output logic [1:0]        field_sel
);

  localparam int OW_W = (OW_CYCLES > 1) ? $clog2(OW_CYCLES) : 1;
  localparam logic [OW_W-1:0] OW_LOAD = OW_W'(OW_CYCLES - 1);

  state_t            state;
  hms_t              edit_q;     // value being edited; time_set is this register
  hms_t              commit_q;   // last value written, restored on cancel
  logic [OW_W-1:0]   ow_cnt;
  logic              mode_prev;
  logic              cancel_prev;
  logic              hist_vld;
  logic              mode_press;
  logic              cancel_press;
  logic              in_set;
  logic              field_clr;
  logic              up_step;
  logic              down_step;
  logic [HOUR_W-1:0] hour_nx;
  logic [MIN_W-1:0]  min_nx;
  logic [SEC_W-1:0]  sec_nx;

  assign in_set       = (state == ST_SET_HOUR) || (state == ST_SET_MIN) || (state == ST_SET_SEC);
  assign mode_press   = btn_mode & ~mode_prev & hist_vld;
  assign cancel_press = btn_cancel & ~cancel_prev & hist_vld;
  // Mode/cancel outrank up/down: their cycle drops any step and resets repeat.
  assign field_clr    = in_set & (mode_press | cancel_press);

  time_setter_btn_repeat #(
    .REPEAT_DLY(REPEAT_DLY),
    .REPEAT_PER(REPEAT_PER)
  ) u_up_rpt (
    .clk    (clk),
    .rst_n  (rst_n),
    .level  (btn_up),
    .enable (in_set),
    .clear  (field_clr),
    .step   (up_step)
  );

  time_setter_btn_repeat #(
    .REPEAT_DLY(REPEAT_DLY),
    .REPEAT_PER(REPEAT_PER)
  ) u_down_rpt (
    .clk    (clk),
    .rst_n  (rst_n),
    .level  (btn_down),
    .enable (in_set),
    .clear  (field_clr),
    .step   (down_step)
  );

  // Steps are already gated to edit states, so these equal the current field
  // value whenever no step is requested (or both directions fire together).
  always_comb begin
    hour_nx = step_hour(edit_q.hour, up_step, down_step);
    min_nx  = step_ms(edit_q.min, up_step, down_step);
    sec_nx  = step_ms(edit_q.sec, up_step, down_step);
  end

  assign time_set = edit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      edit_q      <= '0;
      commit_q    <= '0;
      ow_cnt      <= '0;
      time_ow     <= 1'b0;
      editing     <= 1'b0;
      field_sel   <= FSEL_NONE;
      mode_prev   <= 1'b0;
      cancel_prev <= 1'b0;
      hist_vld    <= 1'b0;
    end else begin
      mode_prev   <= btn_mode;
      cancel_prev <= btn_cancel;
      hist_vld    <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (mode_press) begin
            edit_q    <= time_cur;
            state     <= ST_SET_HOUR;
            editing   <= 1'b1;
            field_sel <= FSEL_HOUR;
          end
        end

        ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: begin
          if (cancel_press) begin
            edit_q    <= commit_q;
            state     <= ST_IDLE;
            editing   <= 1'b0;
            field_sel <= FSEL_NONE;
          end else if (mode_press) begin
            case (state)
              ST_SET_HOUR: begin
                state     <= ST_SET_MIN;
                field_sel <= FSEL_MIN;
              end
              ST_SET_MIN: begin
                state     <= ST_SET_SEC;
                field_sel <= FSEL_SEC;
              end
              default: begin
                // Strobe starts in the same cycle COMMIT is entered.
                state     <= ST_COMMIT;
                commit_q  <= edit_q;
                time_ow   <= 1'b1;
                ow_cnt    <= OW_LOAD;
                editing   <= 1'b0;
                field_sel <= FSEL_NONE;
              end
            endcase
          end else begin
            case (state)
              ST_SET_HOUR: edit_q.hour <= hour_nx;
              ST_SET_MIN:  edit_q.min  <= min_nx;
              default:     edit_q.sec  <= sec_nx;
            endcase
          end
        end

        ST_COMMIT: begin
          if (ow_cnt == '0) begin
            time_ow <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            ow_cnt <= ow_cnt - OW_W'(1);
          end
        end

        default: begin
          state     <= ST_IDLE;
          time_ow   <= 1'b0;
          editing   <= 1'b0;
          field_sel <= FSEL_NONE;
        end
      endcase
    end
  end

endmodule
